noc_mux_rr: RTL and testbench

- Packet-level round-robin multiplexer that merges CHANNELS NoC flit streams onto one output link.
- Sits directly upstream of a NoC FIFO buffer stage and drives its in_flit/in_last/in_valid/in_ready interface.
- A grant is held from the first flit through the last flit of a packet, so packets are never interleaved.
- Output is registered: 1 cycle minimum latency, full throughput (1 flit/cycle).

---
 rtl/noc_mux_rr.sv | 124 ++++++++++++
 tb/tb_noc_mux_rr.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_mux_rr.sv
// Packet-level round-robin multiplexer for NoC flit streams.
// Merges CHANNELS input streams onto one registered output link. A channel
// keeps the grant from its first flit through its last flit, so packets are
// never interleaved. Priority rotates to the channel after the one whose
// packet just completed.
module noc_mux_rr #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]            in_last,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]          out_flit,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int CW = $clog2(CHANNELS);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   grant, prio;
  logic [CW-1:0]   winner, scan_idx, sel;
  logic            found, can_accept, xfer, sel_last;
  logic [FLIT_WIDTH-1:0] sel_flit;

  // Channel index increment modulo CHANNELS; handles non-power-of-2 counts.
  function automatic logic [CW-1:0] next_idx(input logic [CW-1:0] idx);
    return (idx == CW'(CHANNELS - 1)) ? '0 : idx + CW'(1);
  endfunction

  // Round-robin search: first valid channel starting at prio.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    winner   = '0;
    found    = 1'b0;
    scan_idx = prio;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!found && in_valid[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
      scan_idx = next_idx(scan_idx);
    end
  end

  // FSM outputs: choose the served channel, drive its ready, flag a transfer.
  always_comb begin
    can_accept = !out_valid || out_ready;
    in_ready   = '0;
    sel        = '0;
    xfer       = 1'b0;
    if (state == IDLE) begin
      sel  = winner;
      xfer = found && can_accept;
      if (found) in_ready[winner] = can_accept;
    end else begin
      sel             = grant;
      in_ready[grant] = can_accept;
      xfer            = can_accept && in_valid[grant];
    end
  end

  // Data path select of the served channel's flit and last marker.
  always_comb begin
    sel_flit = '0;
    sel_last = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == CW'(i)) begin
        sel_flit = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
        sel_last = in_last[i];
      end
    end
  end

  // Next state: enter ACTIVE on a non-last first flit, leave on the last flit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && !sel_last) state_nxt = ACTIVE;
      ACTIVE:  if (xfer && sel_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant and priority registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      prio  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && xfer) grant <= winner;
      if (xfer && sel_last)      prio  <= next_idx(sel);
    end
  end

  // Output register: load on transfer, otherwise drain when downstream is ready.
  always_ff @(posedge clk) begin
    // NOTE: reset clears the data fields too, so a reset mid-packet leaves nothing stale visible.
    if (!rst) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_flit  <= sel_flit;
      out_last  <= sel_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_mux_rr.sv
// Directed self-checking bench for noc_mux_rr: a 2-channel instance for
// contention, multi-flit, backpressure and reset cases, and a 3-channel
// instance for non-power-of-2 priority wrap-around.
module tb_noc_mux_rr;

  logic        clk = 1'b0;
  logic        rst;

  // 2-channel instance
  logic [63:0] in_flit;
  logic [1:0]  in_last, in_valid, in_ready;
  logic [31:0] out_flit;
  logic        out_last, out_valid, out_ready;

  // 3-channel instance
  logic [95:0] in_flit3;
  logic [2:0]  in_last3, in_valid3, in_ready3;
  logic [31:0] out_flit3;
  logic        out_last3, out_valid3, out_ready3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_mux_rr #(.FLIT_WIDTH(32), .CHANNELS(2)) dut (
    .clk(clk), .rst(rst),
    .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  noc_mux_rr #(.FLIT_WIDTH(32), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_flit(in_flit3), .in_last(in_last3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_flit(out_flit3), .out_last(out_last3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational logic settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic drive(input int ch, input logic [31:0] flit, input logic last, input logic valid);
    in_flit[ch*32 +: 32] = flit;
    in_last[ch]          = last;
    in_valid[ch]         = valid;
  endtask

  task automatic drive3(input int ch, input logic [31:0] flit, input logic last, input logic valid);
    in_flit3[ch*32 +: 32] = flit;
    in_last3[ch]          = last;
    in_valid3[ch]         = valid;
  endtask

  initial begin
    int cnt [2];
    int cnt3 [3];
    logic [2:0] exp_rdy3;

    rst        = 1'b0;
    in_flit    = '0; in_last  = '0; in_valid  = '0; out_ready  = 1'b1;
    in_flit3   = '0; in_last3 = '0; in_valid3 = '0; out_ready3 = 1'b1;

    // ---- Reset then idle ----
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_flit",  out_flit,  0);
    check("rst_last",  out_last,  0);
    rst = 1'b1;
    tick();
    check("idle_valid", out_valid, 0);
    check("idle_ready", in_ready,  2'b00);

    // ---- Single-flit contention: A0,B0,A1,B1,... ----
    cnt[0] = 0; cnt[1] = 0;
    drive(0, 32'hA0, 1'b1, 1'b1);
    drive(1, 32'hB0, 1'b1, 1'b1);
    settle();
    check("rr_pre_valid", out_valid, 0);
    for (int n = 0; n < 6; n++) begin
      int ch;
      ch = n % 2;
      settle();
      check("rr_ready", in_ready, (ch == 0) ? 2'b01 : 2'b10);
      tick();
      check("rr_valid", out_valid, 1);
      check("rr_flit",  out_flit, ((ch == 0) ? 32'hA0 : 32'hB0) + 32'(cnt[ch]));
      cnt[ch]++;
      drive(ch, ((ch == 0) ? 32'hA0 : 32'hB0) + 32'(cnt[ch]), 1'b1, 1'b1);
    end
    in_valid = 2'b00;
    tick();
    check("rr_drain", out_valid, 0);

    // ---- Multi-flit packets: ch0 0x10..0x12, ch1 0x20..0x21 ----
    drive(0, 32'h10, 1'b0, 1'b1);
    settle();
    check("mf_rdy0", in_ready, 2'b01);
    tick();
    check("mf_f10", out_flit, 32'h10);
    drive(0, 32'h11, 1'b0, 1'b1);
    drive(1, 32'h20, 1'b0, 1'b1);
    settle();
    check("mf_rdy1", in_ready, 2'b01);
    tick();
    check("mf_f11", out_flit, 32'h11);
    drive(0, 32'h12, 1'b1, 1'b1);
    settle();
    check("mf_rdy2", in_ready, 2'b01);
    tick();
    check("mf_f12",   out_flit, 32'h12);
    check("mf_last0", out_last, 1);
    drive(0, 32'h0, 1'b0, 1'b0);
    settle();
    check("mf_rdy3", in_ready, 2'b10);
    tick();
    check("mf_f20",  out_flit, 32'h20);
    check("mf_nl20", out_last, 0);
    drive(1, 32'h21, 1'b1, 1'b1);
    settle();
    check("mf_rdy4", in_ready, 2'b10);
    tick();
    check("mf_f21",   out_flit, 32'h21);
    check("mf_last1", out_last, 1);
    in_valid = 2'b00;
    tick();
    check("mf_drain", out_valid, 0);

    // ---- Backpressure during a ch0 packet 0x30..0x32 ----
    drive(0, 32'h30, 1'b0, 1'b1);
    tick();
    check("bp_f30", out_flit, 32'h30);
    drive(0, 32'h31, 1'b0, 1'b1);
    out_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      settle();
      check("bp_rdy",   in_ready,  2'b00);
      tick();
      check("bp_hold",  out_flit,  32'h30);
      check("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    settle();
    check("bp_rel_rdy", in_ready, 2'b01);
    tick();
    check("bp_f31", out_flit, 32'h31);
    drive(0, 32'h32, 1'b1, 1'b1);
    tick();
    check("bp_f32",  out_flit, 32'h32);
    check("bp_last", out_last, 1);
    in_valid = 2'b00;
    tick();
    check("bp_drain", out_valid, 0);

    // ---- Reset mid-packet (prio is now 1) ----
    drive(0, 32'h40, 1'b0, 1'b1);
    tick();
    check("mr_f40", out_flit, 32'h40);
    drive(0, 32'h41, 1'b0, 1'b1);
    tick();
    check("mr_f41", out_flit, 32'h41);
    drive(0, 32'h42, 1'b0, 1'b1);
    rst = 1'b0;
    tick();
    check("mr_valid", out_valid, 0);
    check("mr_flit",  out_flit,  0);
    rst = 1'b1;
    in_valid = 2'b00;
    settle();
    check("mr_idle_rdy", in_ready, 2'b00);
    tick();
    check("mr_no_emit", out_valid, 0);
    drive(0, 32'h50, 1'b1, 1'b1);
    drive(1, 32'h60, 1'b1, 1'b1);
    settle();
    check("mr_prio0", in_ready, 2'b01);
    tick();
    check("mr_f50", out_flit, 32'h50);
    drive(0, 32'h0, 1'b0, 1'b0);
    settle();
    check("mr_ch1_rdy", in_ready, 2'b10);
    tick();
    check("mr_f60", out_flit, 32'h60);
    in_valid = 2'b00;
    tick();

    // ---- CHANNELS=3 wrap: grant sequence 0,1,2,0,1,2 ----
    for (int c = 0; c < 3; c++) begin
      cnt3[c] = 0;
      drive3(c, 32'(c * 16), 1'b1, 1'b1);
    end
    for (int n = 0; n < 6; n++) begin
      int ch;
      ch = n % 3;
      exp_rdy3 = '0;
      exp_rdy3[ch] = 1'b1;
      settle();
      check("w3_ready", in_ready3, exp_rdy3);
      tick();
      check("w3_flit", out_flit3, 32'(ch * 16 + cnt3[ch]));
      cnt3[ch]++;
      drive3(ch, 32'(ch * 16 + cnt3[ch]), 1'b1, 1'b1);
    end
    in_valid3 = 3'b000;
    tick();
    check("w3_drain", out_valid3, 0);
    drive3(2, 32'h77, 1'b1, 1'b1);
    settle();
    check("w3_only2_rdy", in_ready3, 3'b100);
    tick();
    check("w3_only2_flit",  out_flit3,  32'h77);
    check("w3_only2_valid", out_valid3, 1);
    in_valid3 = 3'b000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
